// File: rtl/fb_write_queue_if.sv
// Bus bundle between the display processor write port, the write queue and the
// framebuffer RAM write port.
interface fb_write_queue_if #(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256,
    parameter int DEPTH          = 16
);
    localparam int X_W    = $clog2(RESOLUTION_X);
    localparam int Y_W    = $clog2(RESOLUTION_Y);
    localparam int IDX_W  = $clog2(PALETTE_LENGTH);
    localparam int ADDR_W = $clog2(RESOLUTION_X * RESOLUTION_Y);
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              flush;
    logic [X_W-1:0]    wr_x;
    logic [Y_W-1:0]    wr_y;
    logic [IDX_W-1:0]  wr_index;
    logic              wr_en;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [IDX_W-1:0]  mem_data;
    logic              mem_wr_en;
    logic              mem_stall;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic [15:0]       oob_count;

    modport slave (
        input  flush, wr_x, wr_y, wr_index, wr_en, mem_stall,
        output in_ready, mem_addr, mem_data, mem_wr_en, level, overflow, oob_count
    );

    modport master (
        output flush, wr_x, wr_y, wr_index, wr_en, mem_stall,
        input  in_ready, mem_addr, mem_data, mem_wr_en, level, overflow, oob_count
    );
endinterface

// File: rtl/fb_write_queue.sv
// Range-checks pixel writes, linearises them to framebuffer word addresses and
// queues them for the framebuffer RAM port, draining whenever scanout allows.
module fb_write_queue #(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256,
    parameter int DEPTH          = 16
) (
    input  logic             clk,
    input  logic             reset,
    fb_write_queue_if.slave  bus
);
    localparam int X_W    = $clog2(RESOLUTION_X);
    localparam int Y_W    = $clog2(RESOLUTION_Y);
    localparam int IDX_W  = $clog2(PALETTE_LENGTH);
    localparam int ADDR_W = $clog2(RESOLUTION_X * RESOLUTION_Y);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [IDX_W-1:0]  data;
    } fb_entry_t;

    fb_entry_t         fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  count;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [IDX_W-1:0]  mem_data_q;
    logic              mem_wr_en_q;
    logic              overflow_q;
    logic [15:0]       oob_q;

    logic      full, empty, in_range, accept;
    logic      push, pop, drop_oob, drop_full;
    fb_entry_t push_entry;

    always_comb begin
        full     = (count == LVL_W'(DEPTH));
        empty    = (count == '0);
        // One extra bit so a resolution that is an exact power of two still compares correctly
        in_range = ({1'b0, bus.wr_x} < (X_W+1)'(RESOLUTION_X)) &&
                   ({1'b0, bus.wr_y} < (Y_W+1)'(RESOLUTION_Y));
        accept    = bus.wr_en && !bus.flush;
        drop_oob  = accept && !in_range;
        // Fullness is judged on registered state only; a same-cycle pop does not make room
        push      = accept && in_range && !full;
        drop_full = accept && in_range && full;
        pop       = !empty && !bus.mem_stall && !bus.flush;
        push_entry.addr = ADDR_W'(bus.wr_y) * ADDR_W'(RESOLUTION_X) + ADDR_W'(bus.wr_x);
        push_entry.data = bus.wr_index;
    end

    // Storage needs no reset: occupancy and pointers decide what is valid
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_wr_en_q <= 1'b0;
            overflow_q  <= 1'b0;
            oob_q       <= '0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            mem_wr_en_q <= 1'b0;
        end else begin
            mem_wr_en_q <= pop;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                mem_addr_q <= fifo_mem[rd_ptr].addr;
                mem_data_q <= fifo_mem[rd_ptr].data;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop_full)
                overflow_q <= 1'b1;
            if (drop_oob && oob_q != 16'hFFFF)
                oob_q <= oob_q + 16'd1;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.level     = count;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.mem_wr_en = mem_wr_en_q;
    assign bus.overflow  = overflow_q;
    assign bus.oob_count = oob_q;
endmodule

// File: tb/tb_fb_write_queue.sv
// Scoreboard bench for fb_write_queue: queue-based reference model, directed
// scenarios followed by randomized traffic with stalls and flushes.
module tb_fb_write_queue;
    localparam int RX = 400, RY = 300, PL = 256, DEPTH = 16;
    localparam int X_W = $clog2(RX), Y_W = $clog2(RY), IDX_W = $clog2(PL);

    typedef struct { int addr; int data; } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fb_write_queue_if #(.RESOLUTION_X(RX), .RESOLUTION_Y(RY), .PALETTE_LENGTH(PL), .DEPTH(DEPTH)) bus();
    fb_write_queue #(.RESOLUTION_X(RX), .RESOLUTION_Y(RY), .PALETTE_LENGTH(PL), .DEPTH(DEPTH))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int   errors = 0, checks = 0;
    bit   mon_en = 1'b0;
    ent_t m_q[$];
    ent_t exp_q[$];
    bit   m_ovf;
    int   m_oob;
    int   strobes;

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: occupancy is a queue; popped entries become expected strobes
    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_q.delete(); exp_q.delete(); m_ovf = 1'b0; m_oob = 0;
        end else if (bus.flush) begin
            m_q.delete();
        end else begin
            bit was_full;
            was_full = (m_q.size() == DEPTH);
            if (!bus.mem_stall && m_q.size() > 0)
                exp_q.push_back(m_q.pop_front());
            if (bus.wr_en) begin
                if (int'(bus.wr_x) >= RX || int'(bus.wr_y) >= RY) begin
                    if (m_oob < 65535) m_oob++;
                end else if (was_full) begin
                    m_ovf = 1'b1;
                end else begin
                    ent_t e;
                    e.addr = int'(bus.wr_y) * RX + int'(bus.wr_x);
                    e.data = int'(bus.wr_index);
                    m_q.push_back(e);
                end
            end
        end
    end

    // Monitor: every strobe must match the oldest expected entry, none may be missing
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (bus.mem_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_strobe: got mem_wr_en=1 addr=%0d expected no write at %0t",
                             bus.mem_addr, $time);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("mem_addr", 32'(bus.mem_addr), e.addr);
                    chk("mem_data", 32'(bus.mem_data), e.data);
                end
            end else if (exp_q.size() != 0) begin
                checks++; errors++;
                $display("FAIL missing_strobe: got mem_wr_en=%b expected write addr=%0d at %0t",
                         bus.mem_wr_en, exp_q[0].addr, $time);
                void'(exp_q.pop_front());
            end
            chk("level", 32'(bus.level), m_q.size());
            chk("in_ready", 32'(bus.in_ready), (m_q.size() < DEPTH) ? 1 : 0);
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("oob_count", 32'(bus.oob_count), m_oob);
        end
    end

    task automatic cyc(bit en, int x, int y, int idx, bit stall, bit fl = 1'b0);
        bus.wr_en     = en;
        bus.wr_x      = X_W'(x);
        bus.wr_y      = Y_W'(y);
        bus.wr_index  = IDX_W'(idx);
        bus.mem_stall = stall;
        bus.flush     = fl;
        @(negedge clk);
        if (bus.mem_wr_en === 1'b1) strobes++;
    endtask

    task automatic wr_rand(bit stall);
        cyc(1'b1, $urandom_range(RX-1), $urandom_range(RY-1), $urandom_range(PL-1), stall);
    endtask

    initial begin
        bit heavy;
        cyc(1'b0, 0, 0, 0, 1'b0);
        repeat (2) cyc(1'b0, 0, 0, 0, 1'b0);
        mon_en = 1'b1;
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_mem_wr_en", 32'(bus.mem_wr_en), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        chk("rst_oob", 32'(bus.oob_count), 0);
        reset = 1'b0;
        cyc(1'b0, 0, 0, 0, 1'b0);

        // Two-cycle latency, single strobe
        cyc(1'b1, 5, 2, 'h3C, 1'b0);
        chk("t1_no_strobe_c1", 32'(bus.mem_wr_en), 0);
        cyc(1'b0, 0, 0, 0, 1'b0);
        chk("t1_strobe_c2", 32'(bus.mem_wr_en), 1);
        chk("t1_addr", 32'(bus.mem_addr), 805);
        chk("t1_data", 32'(bus.mem_data), 'h3C);
        cyc(1'b0, 0, 0, 0, 1'b0);
        chk("t1_strobe_once", 32'(bus.mem_wr_en), 0);

        // Corner pixel and out-of-range drops
        cyc(1'b1, 399, 299, 1, 1'b0);
        cyc(1'b1, 400, 0, 2, 1'b0);
        chk("t2_corner_addr", 32'(bus.mem_addr), 119999);
        cyc(1'b1, 0, 300, 3, 1'b0);
        strobes = 0;
        repeat (3) cyc(1'b0, 0, 0, 0, 1'b0);
        chk("t2_no_oob_write", strobes, 0);
        chk("t2_oob", 32'(bus.oob_count), 2);

        // Fill under stall, overflow, then drain 16 in order
        for (int i = 0; i < 17; i++) wr_rand(1'b1);
        cyc(1'b0, 0, 0, 0, 1'b1);
        chk("t3_level", 32'(bus.level), 16);
        chk("t3_in_ready", 32'(bus.in_ready), 0);
        chk("t3_overflow", 32'(bus.overflow), 1);
        strobes = 0;
        repeat (20) cyc(1'b0, 0, 0, 0, 1'b0);
        chk("t3_strobes", strobes, 16);

        // Alternating stall while streaming
        for (int i = 0; i < 8; i++) wr_rand(i % 2 == 0);
        repeat (12) cyc(1'b0, 0, 0, 0, 1'b0);
        chk("t4_level", 32'(bus.level), 0);

        // Reset with queued entries
        for (int i = 0; i < 8; i++) wr_rand(1'b1);
        reset = 1'b1;
        cyc(1'b0, 0, 0, 0, 1'b1);
        reset = 1'b0;
        chk("t5_level", 32'(bus.level), 0);
        chk("t5_overflow", 32'(bus.overflow), 0);
        chk("t5_oob", 32'(bus.oob_count), 0);
        strobes = 0;
        repeat (6) cyc(1'b0, 0, 0, 0, 1'b0);
        chk("t5_no_strobes", strobes, 0);

        // Flush keeps overflow, discards same-cycle write
        for (int i = 0; i < 17; i++) wr_rand(1'b1);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) wr_rand(1'b1);
        chk("t6_level_before", 32'(bus.level), 4);
        cyc(1'b1, 7, 7, 7, 1'b1, 1'b1);
        chk("t6_level", 32'(bus.level), 0);
        chk("t6_overflow", 32'(bus.overflow), 1);
        strobes = 0;
        repeat (6) cyc(1'b0, 0, 0, 0, 1'b0);
        chk("t6_no_strobes", strobes, 0);

        // Randomized traffic; stays in range whenever the queue is full
        heavy = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int x, y;
            bit en, st, fl;
            if (n % 150 == 0) heavy = ~heavy;
            en = ($urandom_range(3) != 0);
            x  = $urandom_range(511);
            y  = $urandom_range(511);
            if (m_q.size() == DEPTH) begin
                x = x % RX;
                y = y % RY;
            end
            st = heavy ? ($urandom_range(9) != 0) : ($urandom_range(3) == 0);
            fl = ($urandom_range(99) == 0);
            cyc(en, x, y, $urandom_range(PL-1), st, fl);
        end
        repeat (DEPTH + 4) cyc(1'b0, 0, 0, 0, 1'b0);
        chk("rand_drained", 32'(bus.level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
